// File: rtl/arb_pkg.sv
// arb_pkg: shared board geometry, types and scan FSM states for arb and arb_scan.
package arb_pkg;
    localparam int NUM_SQ = 64;
    localparam int PRIO_W = 3;
    localparam int SQ_W   = 6;
    typedef logic [PRIO_W-1:0] prio_t;
    typedef logic [SQ_W-1:0]   square_t;
    typedef enum logic [1:0] {IDLE, SCAN, PRESENT} state_t;
endpackage

// File: rtl/arb.sv
// arb: combinational picker of the highest-priority square, lowest index on ties.
// data_out = {empty, square}; empty is set when every priority is zero.
module arb
    import arb_pkg::*;
(
    input  logic [NUM_SQ*PRIO_W-1:0] priority_,
    output logic [SQ_W:0]            data_out
);
    prio_t   best;
    square_t idx;
    // Descending scan with >= leaves the lowest index holding the maximum.
    always_comb begin
        best = '0;
        idx  = '0;
        for (int i = NUM_SQ - 1; i >= 0; i--) begin
            if (priority_[i*PRIO_W +: PRIO_W] >= best) begin
                best = priority_[i*PRIO_W +: PRIO_W];
                idx  = square_t'(i);
            end
        end
        data_out = {best == '0, idx};
    end
endmodule

// File: rtl/arb_scan.sv
// arb_scan: latches a priority board and streams squares out best-first until it is empty.
// Optional ARB_SCAN_COUNT_EN adds a count of squares handshaken since the last start.
module arb_scan
    import arb_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NUM_SQ*PRIO_W-1:0] prio_in,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SQ_W-1:0]          out_square,
    output logic [PRIO_W-1:0]        out_prio,
`ifdef ARB_SCAN_COUNT_EN
    output logic [6:0]               count,
`endif
    output logic                     done
);
    state_t                    state_q;
    logic [NUM_SQ*PRIO_W-1:0]  board_q;
    logic [NUM_SQ*PRIO_W-1:0]  board_d;
    logic [SQ_W:0]             arb_out;
    prio_t                     board_arr [NUM_SQ];
    logic [NUM_SQ-1:0]         clr_oh;
    logic                      hs;

    arb u_arb (
        .priority_ (board_q),
        .data_out  (arb_out)
    );

    assign busy   = state_q != IDLE;
    assign hs     = state_q == PRESENT && out_ready;
    assign clr_oh = NUM_SQ'(1) << out_square;

    // Board after the presented square is consumed: its field is zeroed.
    always_comb begin
        for (int i = 0; i < NUM_SQ; i++) begin
            board_arr[i]                = board_q[i*PRIO_W +: PRIO_W];
            board_d[i*PRIO_W +: PRIO_W] = clr_oh[i] ? prio_t'(0) : board_q[i*PRIO_W +: PRIO_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            board_q    <= '0;
            out_valid  <= 1'b0;
            out_square <= '0;
            out_prio   <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    board_q <= prio_in;
                    state_q <= SCAN;
                end
                SCAN: if (arb_out[SQ_W]) begin
                    done    <= 1'b1;
                    state_q <= IDLE;
                end else begin
                    out_square <= arb_out[SQ_W-1:0];
                    out_prio   <= board_arr[arb_out[SQ_W-1:0]];
                    out_valid  <= 1'b1;
                    state_q    <= PRESENT;
                end
                PRESENT: if (out_ready) begin
                    board_q   <= board_d;
                    out_valid <= 1'b0;
                    state_q   <= SCAN;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ARB_SCAN_COUNT_EN
    logic [6:0] count_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= '0;
        else if (state_q == IDLE && start)
            count_q <= '0;
        else if (hs)
            count_q <= count_q + 7'd1;
    end
    assign count = count_q;
`endif
endmodule

// File: doc/arb_scan.md
Name: arb_scan

Overview:
- Sequential driver wrapped around the existing combinational `arb` stage.
- Latches a 64-square × 3-bit priority board and feeds it to `arb`.
- Emits squares one at a time, highest priority first, over a valid/ready stream. Ties go to the lowest square index.
- Each emitted square's priority is zeroed and the scan repeats until `arb` reports no non-zero priority. Sits between the per-square scoring logic (upstream) and the move consumer (downstream).

Parameters:
- NUM_SQ, 64, squares on the board; fixed, the `arb` sub-module is hard-wired to 64.
- PRIO_W, 3, priority bits per square; 0 means "not a candidate".
- SQ_W, 6, square index width, laid out as {rank[2:0], file[2:0]}.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  load request; sampled only in IDLE.
- prio_in  in  192  board priorities; square s at bits [3s+2:3s].
- busy  out  1  high in any state other than IDLE.
- out_valid  out  1  a square is presented.
- out_ready  in  1  consumer accepts the presented square.
- out_square  out  6  index of the presented square.
- out_prio  out  3  priority of the presented square, read from the board at latch time.
- done  out  1  one-cycle pulse when the board is exhausted.

Behaviour:
- Reset (async assert, sync-released use): state=IDLE, board=0, out_valid=0, out_square=0, out_prio=0, done=0. Reset mid-scan abandons the scan immediately; no done pulse.
- Board register: 192 bits. Drives `arb.priority_`. `arb.data_out` is combinational: [5:0] winning square, [6] empty flag.
- State IDLE:
  - start=1 → board<=prio_in, next SCAN.
  - start=0 → stay in IDLE.
- State SCAN (one cycle):
  - empty=1 → done<=1 for one cycle, next IDLE.
  - Else out_square<=arb square, out_prio<=board[that square], out_valid<=1, next PRESENT.
- State PRESENT:
  - Hold out_valid, out_square, out_prio stable until out_valid&&out_ready.
  - On handshake: board[out_square]<=0, out_valid<=0, next SCAN.
- Throughput: 2 cycles per square with out_ready held high.
  - Latency from start to first out_valid: 2 cycles (IDLE→SCAN→PRESENT).
  - Board with N non-zero squares: done asserts 2N+2 cycles after start.
- start while busy: ignored; the board is not reloaded.
- All-zero board: start → SCAN → done pulse, no out_valid.
- out_ready with out_valid=0: no effect.
- done is never asserted together with out_valid.
- Ordering: the `arb` tie rule applies. Equal priorities emit in ascending square index. Strictly higher priority always emits first.

Optional Feature:
- Macro ARB_SCAN_COUNT_EN.
- Defined:
  - Adds output `count` [6:0]: number of squares handshaken since the last start.
  - Cleared on reset and on an accepted start; incremented on each handshake.
  - Holds its value after done until the next start. Maximum value is 64, which fits in 7 bits.
- Undefined: no `count` port, no counter logic; all other behaviour identical.

Decomposition:
- Package arb_pkg:
  - localparams NUM_SQ=64, PRIO_W=3, SQ_W=6.
  - typedef prio_t logic[2:0]; typedef square_t logic[5:0].
  - typedef enum state_t {IDLE, SCAN, PRESENT}.
- Sub-module: the existing `arb`, instantiated once as `u_arb`. No other hierarchy.
- Board clear: 64-way one-hot decode of out_square masking 3-bit fields.

Test Plan:
- Reset mid-PRESENT: assert rst while out_valid=1 → out_valid=0, busy=0 and done=0 same cycle. The next start behaves normally.
- All-zero prio_in, start → busy for 1 cycle, done pulse at cycle 2, out_valid never high; count=0 with ARB_SCAN_COUNT_EN.
- sq 5 prio 3, sq 40 prio 7, sq 12 prio 3, rest 0, out_ready=1 → emits (40,7), (5,3), (12,3) on cycles 2, 4, 6; done on cycle 8; count=3.
- Backpressure: same board, out_ready=0 for 10 cycles at first out_valid → out_square stays 40 and out_prio stays 7; the board is unchanged until ready rises.
- All 64 squares prio 1 → emits squares 0..63 in order, done at cycle 130, count=64.
- start pulsed during PRESENT with a different prio_in → ignored; the original sequence completes unchanged.
